aes_key_expander: RTL and testbench

Sequential AES-128 key schedule feeding the round datapath. Accepts a 128-bit cipher key over a valid/ready handshake and streams the 11 round keys (round 0 through round 10) one per cycle on a second valid/ready interface. The `round_key` output connects directly to the round-key input of the MixColumns/AddRoundKey XOR network, using the same byte ordering: byte k occupies bits [127-8k : 120-8k].

---
 rtl/aes_key_expander.sv | 156 +++++++++++++++
 tb/tb_aes_key_expander.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Sequential AES-128 key schedule: accepts a cipher key and streams round keys 0..10, one per handshake.
// Optional AES_KEYSCHED_REVERSE_EN adds a `reverse` input that precomputes round 10 and streams keys 10..0.
`timescale 1ns/1ps

module aes_key_expander (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
`ifdef AES_KEYSCHED_REVERSE_EN
  input  logic         reverse,
`endif
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);

`ifdef AES_KEYSCHED_REVERSE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, PRECOMP = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;
`endif

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[2047 - 8*int'(x) -: 8];
  endfunction

  // SubWord(RotWord(w)): rotate bytes left by one, then substitute each byte.
  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] b);
    return (b == 8'h1b) ? 8'h80 : {1'b0, b[7:1]};
  endfunction

  state_t         state_q, state_d;
  logic [127:0]   key_d;
  logic [3:0]     idx_d;
  logic [7:0]     rcon_q, rcon_d;
  logic           dir_q, dir_d;

  logic [31:0] w0, w1, w2, w3, sub_in, sub_out;
  logic [31:0] f0, f1, f2, f3, i0, i1, i2, i3;

  assign {w0, w1, w2, w3} = round_key;

  // One shared set of four S-box lookups serves both directions; only the input word differs.
  assign i3      = w3 ^ w2;
  assign i2      = w2 ^ w1;
  assign i1      = w1 ^ w0;
  assign sub_in  = (dir_q && state_q == STREAM) ? i3 : w3;
  assign sub_out = sub_rot(sub_in);

  assign f0 = w0 ^ sub_out ^ {rcon_q, 24'h0};
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;
  assign i0 = w0 ^ sub_out ^ {rcon_q, 24'h0};

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == STREAM);
  assign busy      = (state_q != IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    key_d   = round_key;
    idx_d   = round_idx;
    rcon_d  = rcon_q;
    dir_d   = dir_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          key_d  = key_in;
          idx_d  = 4'd0;
          rcon_d = 8'h01;
`ifdef AES_KEYSCHED_REVERSE_EN
          dir_d   = reverse;
          state_d = reverse ? PRECOMP : STREAM;
`else
          dir_d   = 1'b0;
          state_d = STREAM;
`endif
        end
      end
`ifdef AES_KEYSCHED_REVERSE_EN
      PRECOMP: begin
        key_d = {f0, f1, f2, f3};
        idx_d = round_idx + 4'd1;
        // The last step keeps rcon at 0x36: that is the constant the first inverse step needs.
        if (round_idx == 4'd9) state_d = STREAM;
        else                   rcon_d  = xtime(rcon_q);
      end
`endif
      STREAM: begin
        if (rk_ready) begin
          if (dir_q) begin
            if (round_idx == 4'd0) begin
              state_d = IDLE;
            end else begin
              key_d  = {i0, i1, i2, i3};
              idx_d  = round_idx - 4'd1;
              rcon_d = inv_xtime(rcon_q);
            end
          end else begin
            if (round_idx == 4'd10) begin
              state_d = IDLE;
            end else begin
              key_d  = {f0, f1, f2, f3};
              idx_d  = round_idx + 4'd1;
              rcon_d = xtime(rcon_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      round_key <= '0;
      round_idx <= '0;
      rcon_q    <= 8'h01;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_key <= key_d;
      round_idx <= idx_d;
      rcon_q    <= rcon_d;
      dir_q     <= dir_d;
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors, scoreboard of expected round keys.
// Reverse-mode sequence is compiled in when AES_KEYSCHED_REVERSE_EN is defined.
`timescale 1ns/1ps

module tb_aes_key_expander;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] rk;
    bit           has_key;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
`ifdef AES_KEYSCHED_REVERSE_EN
  logic         reverse;
`endif
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int hs     = 0;

  exp_t fips[11];
  exp_t zero_tab[11];
  exp_t sb[$];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expander dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
`ifdef AES_KEYSCHED_REVERSE_EN
    .reverse   (reverse),
`endif
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare any handshake due at the coming edge against the scoreboard, then advance one cycle.
  task automatic cycle();
    exp_t e;
    if (rk_valid && rk_ready) begin
      hs++;
      if (sb.size() == 0) begin
        check("unexpected_round_key", {124'h0, round_idx}, 128'hffff);
      end else begin
        e = sb.pop_front();
        check("rk_idx", {124'h0, round_idx}, {124'h0, e.idx});
        if (e.has_key) check("rk_key", round_key, e.rk);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] k, input logic rev);
    key_in    = k;
    key_valid = 1'b1;
`ifdef AES_KEYSCHED_REVERSE_EN
    reverse   = rev;
`else
    if (rev) $display("reverse requested without AES_KEYSCHED_REVERSE_EN");
`endif
    hs = 0;
    cycle();
    key_valid = 1'b0;
    key_in    = '0;
  endtask

  task automatic push_table(input exp_t tab[11], input bit rev);
    for (int i = 0; i < 11; i++) sb.push_back(rev ? tab[10 - i] : tab[i]);
  endtask

  task automatic drain(output int n);
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      cycle();
      n++;
    end
    check("drain_done", 128'(sb.size()), 128'd0);
  endtask

  task automatic run_to_idx(input logic [3:0] target);
    int n = 0;
    while (!(rk_valid && round_idx == target) && n < 30) begin
      cycle();
      n++;
    end
    check("reach_idx", {124'h0, round_idx}, {124'h0, target});
  endtask

  initial begin
    int n;
    logic [127:0] r[11];
    r[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    r[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    r[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    r[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    r[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    r[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    r[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    r[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    r[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    r[9]  = 128'hac7766f319fadc2128d12941575c006e;
    r[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int i = 0; i < 11; i++) begin
      fips[i]     = '{idx: 4'(i), rk: r[i], has_key: 1'b1};
      zero_tab[i] = '{idx: 4'(i), rk: '0, has_key: 1'b0};
    end
    zero_tab[0] = '{idx: 4'd0, rk: 128'h0, has_key: 1'b1};
    zero_tab[1] = '{idx: 4'd1, rk: 128'h62636363626363636263636362636363, has_key: 1'b1};
    zero_tab[2] = '{idx: 4'd2, rk: 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, has_key: 1'b1};

    rst = 1'b1; key_in = '0; key_valid = 1'b0; rk_ready = 1'b0;
`ifdef AES_KEYSCHED_REVERSE_EN
    reverse = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_rk_valid",  {127'h0, rk_valid},  128'd0);
    check("reset_round_key", round_key,           128'd0);
    check("reset_round_idx", {124'h0, round_idx}, 128'd0);
    check("reset_busy",      {127'h0, busy},      128'd0);
    check("reset_key_ready", {127'h0, key_ready}, 128'd1);

    // rk_ready in IDLE has no effect.
    rk_ready = 1'b1;
    repeat (3) cycle();
    check("idle_ready_no_valid", {127'h0, rk_valid}, 128'd0);
    check("idle_ready_no_busy",  {127'h0, busy},     128'd0);

    // Forward FIPS vector at full throughput, then a back-to-back zero key.
    push_table(fips, 1'b0);
    load(FIPS_KEY, 1'b0);
    check("fwd_latency_valid", {127'h0, rk_valid}, 128'd1);
    check("fwd_key_ready_low", {127'h0, key_ready}, 128'd0);
    drain(n);
    check("fwd_cycles", 128'(n), 128'd11);
    check("fwd_handshakes", 128'(hs), 128'd11);
    check("b2b_key_ready", {127'h0, key_ready}, 128'd1);
    check("b2b_idle_no_valid", {127'h0, rk_valid}, 128'd0);
    push_table(zero_tab, 1'b0);
    load(128'h0, 1'b0);
    check("b2b_accepted", {127'h0, rk_valid}, 128'd1);
    drain(n);
    check("b2b_handshakes", 128'(hs), 128'd11);

    // Backpressure at round 4 with an ignored key pulse during the stall.
    push_table(fips, 1'b0);
    load(FIPS_KEY, 1'b0);
    run_to_idx(4'd4);
    rk_ready = 1'b0;
    key_in = 128'hdeadbeef00112233445566778899aabb;
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      key_valid = 1'b0;
      check("stall_key", round_key, fips[4].rk);
      check("stall_idx", {124'h0, round_idx}, 128'd4);
      check("stall_valid", {127'h0, rk_valid}, 128'd1);
    end
    check("stall_key_ready", {127'h0, key_ready}, 128'd0);
    rk_ready = 1'b1;
    drain(n);
    check("stall_handshakes", 128'(hs), 128'd11);

    // Reset in the middle of a stream, then a fresh load.
    push_table(fips, 1'b0);
    load(FIPS_KEY, 1'b0);
    run_to_idx(4'd6);
    #2 rst = 1'b1;
    #1;
    check("midrst_rk_valid", {127'h0, rk_valid}, 128'd0);
    check("midrst_busy",     {127'h0, busy},     128'd0);
    check("midrst_idx",      {124'h0, round_idx}, 128'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    check("midrst_key_ready", {127'h0, key_ready}, 128'd1);
    check("midrst_no_partial", {127'h0, rk_valid}, 128'd0);
    push_table(fips, 1'b0);
    load(FIPS_KEY, 1'b0);
    drain(n);
    check("midrst_handshakes", 128'(hs), 128'd11);

`ifdef AES_KEYSCHED_REVERSE_EN
    // Reverse stream: ten precompute cycles, then keys 10 down to 0.
    push_table(fips, 1'b1);
    load(FIPS_KEY, 1'b1);
    n = 0;
    while (!rk_valid && n < 20) begin
      if (busy) n++;
      cycle();
    end
    check("rev_busy_cycles", 128'(n), 128'd10);
    drain(n);
    check("rev_handshakes", 128'(hs), 128'd11);
    check("rev_back_idle", {127'h0, key_ready}, 128'd1);
    // reverse=0 still streams forward.
    push_table(fips, 1'b0);
    load(FIPS_KEY, 1'b0);
    drain(n);
    check("rev_off_handshakes", 128'(hs), 128'd11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
